// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings for the two-master arbiter: transfer types,
// response codes and the data-phase owner tag.
package ahblite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_M0   = 2'b01,
        OWNER_M1   = 2'b10
    } owner_e;

endpackage

// File: rtl/ahblite_arb_port.sv
// One master-facing port of the arbiter: pending address-phase register,
// request-source selection and per-master HREADY/HRESP generation.
module ahblite_arb_port
    import ahblite_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic        hready_i,
    input  logic        hresp_i,
    input  logic        win_i,
    input  logic        owner_i,
    output logic        req_o,
    output logic [31:0] src_addr_o,
    output logic [1:0]  src_trans_o,
    output logic        src_write_o,
    output logic [2:0]  src_size_o,
    output logic        mhready_o,
    output logic        mhresp_o
);

    logic        pend_q, pend_d;
    logic [31:0] paddr_q, paddr_d;
    logic [1:0]  ptrans_q, ptrans_d;
    logic        pwrite_q, pwrite_d;
    logic [2:0]  psize_q, psize_d;
    logic        live;
    logic        accept;

    // A pending master is stalled until its captured transfer finishes its data phase.
    assign mhready_o = pend_q ? 1'b0 : (owner_i ? hready_i : 1'b1);
    assign mhresp_o  = owner_i ? hresp_i : HRESP_OKAY;

    assign live   = htrans_i[1] & mhready_o;
    assign accept = hready_i & win_i;
    assign req_o  = pend_q | live;

    assign src_addr_o  = pend_q ? paddr_q  : haddr_i;
    assign src_trans_o = pend_q ? ptrans_q : htrans_i;
    assign src_write_o = pend_q ? pwrite_q : hwrite_i;
    assign src_size_o  = pend_q ? psize_q  : hsize_i;

    always_comb begin
        pend_d   = pend_q;
        paddr_d  = paddr_q;
        ptrans_d = ptrans_q;
        pwrite_d = pwrite_q;
        psize_d  = psize_q;
        if (pend_q && accept) begin
            pend_d = 1'b0;
        end else if (live && !accept) begin
            pend_d   = 1'b1;
            paddr_d  = haddr_i;
            ptrans_d = htrans_i;
            pwrite_d = hwrite_i;
            psize_d  = hsize_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q   <= 1'b0;
            paddr_q  <= '0;
            ptrans_q <= HTRANS_IDLE;
            pwrite_q <= 1'b0;
            psize_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            paddr_q  <= paddr_d;
            ptrans_q <= ptrans_d;
            pwrite_q <= pwrite_d;
            psize_q  <= psize_d;
        end
    end

endmodule

// File: rtl/ahblite_arbiter_2m.sv
// Two-master AHB-Lite arbiter: picks one address phase per HREADY cycle,
// tracks data-phase ownership and routes HWDATA/HREADY/HRESP accordingly.
module ahblite_arbiter_2m
    import ahblite_pkg::*;
(
    input  logic        RR_EN,
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HRESP,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HRESP,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    // last_grant: 0 = M0, 1 = M1
    logic        lg_q, lg_d;
    owner_e      owner_q, owner_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic        hold_write_q, hold_write_d;
    logic [2:0]  hold_size_q, hold_size_d;

    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic [1:0]  trans0, trans1;
    logic        write0, write1;
    logic [2:0]  size0, size1;

    logic        lg_req;
    logic [1:0]  lg_trans;
    logic        win_valid, win_sel;
    logic        grant_valid, grant_sel;

    ahblite_arb_port u_port0 (
        .clk_i(HCLK), .rst_i(HRESET),
        .haddr_i(M0_HADDR), .htrans_i(M0_HTRANS), .hwrite_i(M0_HWRITE), .hsize_i(M0_HSIZE),
        .hready_i(HREADY), .hresp_i(HRESP),
        .win_i(win_valid & ~win_sel), .owner_i(owner_q == OWNER_M0),
        .req_o(req0), .src_addr_o(addr0), .src_trans_o(trans0),
        .src_write_o(write0), .src_size_o(size0),
        .mhready_o(M0_HREADY), .mhresp_o(M0_HRESP)
    );

    ahblite_arb_port u_port1 (
        .clk_i(HCLK), .rst_i(HRESET),
        .haddr_i(M1_HADDR), .htrans_i(M1_HTRANS), .hwrite_i(M1_HWRITE), .hsize_i(M1_HSIZE),
        .hready_i(HREADY), .hresp_i(HRESP),
        .win_i(win_valid & win_sel), .owner_i(owner_q == OWNER_M1),
        .req_o(req1), .src_addr_o(addr1), .src_trans_o(trans1),
        .src_write_o(write1), .src_size_o(size1),
        .mhready_o(M1_HREADY), .mhresp_o(M1_HRESP)
    );

    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;

    assign lg_req   = lg_q ? req1 : req0;
    assign lg_trans = lg_q ? trans1 : trans0;

    // A SEQ beat from the last granted master locks the bus for the rest of its burst.
    always_comb begin
        win_valid = 1'b0;
        win_sel   = lg_q;
        if (lg_req && lg_trans == HTRANS_SEQ) begin
            win_valid = 1'b1;
            win_sel   = lg_q;
        end else if (req0 && req1) begin
            win_valid = 1'b1;
            win_sel   = RR_EN ? ~lg_q : 1'b0;
        end else if (req0) begin
            win_valid = 1'b1;
            win_sel   = 1'b0;
        end else if (req1) begin
            win_valid = 1'b1;
            win_sel   = 1'b1;
        end
    end

    // During slave wait states the grant is frozen on last_grant.
    assign grant_valid = HREADY ? win_valid : lg_req;
    assign grant_sel   = HREADY ? win_sel   : lg_q;

    always_comb begin
        HTRANS = HTRANS_IDLE;
        HADDR  = hold_addr_q;
        HWRITE = hold_write_q;
        HSIZE  = hold_size_q;
        if (grant_valid) begin
            HTRANS = grant_sel ? trans1 : trans0;
            HADDR  = grant_sel ? addr1  : addr0;
            HWRITE = grant_sel ? write1 : write0;
            HSIZE  = grant_sel ? size1  : size0;
        end else if (lg_trans == HTRANS_BUSY) begin
            HTRANS = HTRANS_BUSY;
            HADDR  = lg_q ? addr1  : addr0;
            HWRITE = lg_q ? write1 : write0;
            HSIZE  = lg_q ? size1  : size0;
        end
    end

    always_comb begin
        HWDATA = '0;
        case (owner_q)
            OWNER_M0: HWDATA = M0_HWDATA;
            OWNER_M1: HWDATA = M1_HWDATA;
            default:  HWDATA = '0;
        endcase
    end

    always_comb begin
        lg_d         = lg_q;
        owner_d      = owner_q;
        hold_addr_d  = hold_addr_q;
        hold_write_d = hold_write_q;
        hold_size_d  = hold_size_q;
        if (HREADY) begin
            if (win_valid) begin
                lg_d         = win_sel;
                owner_d      = win_sel ? OWNER_M1 : OWNER_M0;
                hold_addr_d  = win_sel ? addr1  : addr0;
                hold_write_d = win_sel ? write1 : write0;
                hold_size_d  = win_sel ? size1  : size0;
            end else begin
                owner_d = OWNER_NONE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            lg_q         <= 1'b1;
            owner_q      <= OWNER_NONE;
            hold_addr_q  <= '0;
            hold_write_q <= 1'b0;
            hold_size_q  <= '0;
        end else begin
            lg_q         <= lg_d;
            owner_q      <= owner_d;
            hold_addr_q  <= hold_addr_d;
            hold_write_q <= hold_write_d;
            hold_size_q  <= hold_size_d;
        end
    end

endmodule
